accum_cpu_core: RTL and testbench
=================================

Name: accum_cpu_core

Overview:
- 16-bit accumulator processor core: controller FSM, register datapath, ALU built on a shared 16-bit add/subtract unit, and an iterative unsigned divider.
- Drives an external 256x16 RAM. The RAM has combinational read and a write enable.
- Executes a program from address 0 after reset. Results are stored back to RAM; benches check the stored words, e.g. the word at 0x0E.

Parameters:
- ADDR_W, 8, memory address / PC / MAR width. Only the default is supported.
- DATA_W, 16, data / ACC / MDR / IR width. Only the default is supported.

Ports:
- clk  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-high reset.
- mem_addr  out  8  RAM address; always equals MAR.
- mem_wdata  out  16  RAM write data; always equals ACC.
- mem_we  out  1  RAM write enable; high only in state ST.
- mem_rdata  in  16  RAM read data; combinational function of mem_addr.

Behaviour:
- Registers: PC[7:0], MAR[7:0], IR[15:0], MDR[15:0], ACC[15:0], state.
- Instruction fields: opcode = IR[15:8], operand address = IR[7:0].
- zflag = (ACC == 0), combinational.
- Reset (sampled on a rising edge with Reset=1):
  - All registers go to 0, the state goes to F1, the divider goes idle.
  - mem_we=0 during and after reset.
  - Reset asserted mid-instruction or mid-divide aborts it and takes priority.
- Opcodes:
  - 01 ADD: ACC=ACC+M
  - 02 SUB: ACC=ACC-M
  - 03 OR: ACC=ACC|M
  - 04 LOAD: ACC=M
  - 05 STORE: M[a]=ACC
  - 06 JUMP: PC=a
  - 07 JUMPZ: PC=a if zflag
  - 08 DIV: ACC=ACC/M, unsigned quotient
  - FF HALT
  - Any other opcode is a NOP.
  - ADD and SUB are modulo 2^16; carry/borrow is discarded.
- FSM, one state per cycle:
  - F1: MAR<=PC.
  - F2: MDR<=mem_rdata; PC<=PC+1 (0xFF wraps to 0x00).
  - F3: IR<=MDR.
  - D: MAR<=IR[7:0], then branch on opcode:
    - ADD/SUB/OR/LOAD/DIV go to X1.
    - STORE goes to ST.
    - JUMP loads PC<=IR[7:0] and goes to F1.
    - JUMPZ loads PC<=IR[7:0] only if zflag, and goes to F1.
    - HALT goes to H.
    - NOP goes to F1.
  - X1: MDR<=mem_rdata. DIV goes to DV; all others go to X2.
  - X2: ACC<=ALU(ACC, MDR), then F1.
  - ST: mem_we=1 for exactly one cycle, then F1.
  - DV: divider runs; on done, ACC<=quotient, then F1.
  - H: stay in H forever; mem_we=0; only Reset leaves H.
- Latency in cycles, counted from entering F1 to entering the next F1:
  - NOP, JUMP, JUMPZ: 4.
  - STORE: 5.
  - ADD, SUB, OR, LOAD: 6.
  - DIV: 5 + 17.
- Divider:
  - Radix-2 restoring, unsigned: 16 iteration cycles plus 1 result cycle.
  - Remainder is discarded.
  - Divisor 0: quotient = 0xFFFF, with the same fixed latency.
  - Dividend < divisor: quotient 0.
- All arithmetic (ADD, SUB, and divider trial subtraction) uses the single addsub16 instance:
  - sub=1 computes A + ~B + 1; cout = 1 means no borrow.

Decomposition:
- Shared package cpu_pkg:
  - opcode localparams (OP_ADD..OP_HALT);
  - state enum (F1, F2, F3, D, X1, X2, ST, DV, H);
  - ALU op enum (PASS, ADD, SUB, OR).
- Natural sub-module: addsub16.
  - Ports: a[15:0], b[15:0], sub, sum[15:0], cout.
  - Ripple carry, gate level.
- The controller and datapath may be split into separate modules inside accum_cpu_core.

Test Plan:
- Program: 0x040A, 0x010B, 0x050E, 0xFF00, with M[0A]=0x0014 and M[0B]=0x0003 -> M[0E]=0x0017. The core reaches H and mem_we stays 0 afterwards.
- DIV program: LOAD 0A, DIV 0B, STORE 0E, HALT, with 100 / 7 -> M[0E]=0x000E. ACC is updated exactly 22 cycles after the DIV F1. Repeat with divisor 0 -> 0xFFFF; repeat with 5/9 -> 0x0000.
- SUB to zero: LOAD 0A, SUB 0A, JUMPZ 10 -> PC=0x10 and execution continues at 0x10. With a non-zero ACC, JUMPZ falls through to PC=3.
- Arithmetic wrap: 0xFFFF + 0x0002 -> ACC=0x0001. 0x0000 - 0x0001 -> ACC=0xFFFF.
- Reset asserted during DV and during ST -> next cycle all registers are 0, mem_we=0, and execution restarts at address 0.
- PC wrap: JUMP FF, with M[FF] a NOP -> the next fetch is from 0x00.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator core: opcodes, controller states, ALU ops.
package cpu_pkg;

  localparam logic [7:0] OP_ADD   = 8'h01;
  localparam logic [7:0] OP_SUB   = 8'h02;
  localparam logic [7:0] OP_OR    = 8'h03;
  localparam logic [7:0] OP_LOAD  = 8'h04;
  localparam logic [7:0] OP_STORE = 8'h05;
  localparam logic [7:0] OP_JUMP  = 8'h06;
  localparam logic [7:0] OP_JUMPZ = 8'h07;
  localparam logic [7:0] OP_DIV   = 8'h08;
  localparam logic [7:0] OP_HALT  = 8'hFF;

  localparam logic [3:0] S_F1 = 4'd0;
  localparam logic [3:0] S_F2 = 4'd1;
  localparam logic [3:0] S_F3 = 4'd2;
  localparam logic [3:0] S_D  = 4'd3;
  localparam logic [3:0] S_X1 = 4'd4;
  localparam logic [3:0] S_X2 = 4'd5;
  localparam logic [3:0] S_ST = 4'd6;
  localparam logic [3:0] S_DV = 4'd7;
  localparam logic [3:0] S_H  = 4'd8;

  typedef enum logic [1:0] {
    ALU_PASS = 2'd0,
    ALU_ADD  = 2'd1,
    ALU_SUB  = 2'd2,
    ALU_OR   = 2'd3
  } alu_op_t;

  // LOAD and every non-arithmetic opcode simply pass the memory operand.
  function automatic alu_op_t alu_op_of(input logic [7:0] op);
    case (op)
      OP_ADD:  return ALU_ADD;
      OP_SUB:  return ALU_SUB;
      OP_OR:   return ALU_OR;
      default: return ALU_PASS;
    endcase
  endfunction

endpackage

// File: rtl/addsub16.sv
// 16-bit ripple-carry adder/subtractor; sub=1 gives a + ~b + 1, cout=1 meaning no borrow.
module addsub16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        sub,
  output logic [15:0] sum,
  output logic        cout
);

  logic [15:0] bx;
  logic [16:0] c;

  assign bx   = b ^ {16{sub}};
  assign c[0] = sub;

  for (genvar i = 0; i < 16; i++) begin : g_fa
    assign sum[i]   = a[i] ^ bx[i] ^ c[i];
    assign c[i + 1] = (a[i] & bx[i]) | (c[i] & (a[i] ^ bx[i]));
  end

  assign cout = c[16];

endmodule

// File: rtl/accum_cpu_core.sv
// Accumulator processor core: multi-cycle fetch/decode/execute controller with
// datapath registers and a restoring divider sharing one add/subtract unit.
//
// state | meaning
// F1    | MAR <= PC
// F2    | MDR <= instruction word, PC <= PC + 1
// F3    | IR <= MDR
// D     | MAR <= operand address, dispatch on opcode
// X1    | MDR <= memory operand
// X2    | ACC <= ALU(ACC, MDR)
// ST    | write ACC to M[MAR]
// DV    | 16 divide iterations then one result cycle
// H     | halted until Reset
module accum_cpu_core
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              Reset,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic [3:0]  state;
  logic [7:0]  pc;
  logic [7:0]  mar;
  logic [15:0] ir;
  logic [15:0] mdr;
  logic [15:0] acc;
  logic [15:0] rem;
  logic [15:0] quo;
  logic [4:0]  div_cnt;

  logic [7:0]  opcode;
  logic        zflag;
  alu_op_t     alu_op;
  logic [15:0] alu_res;

  logic [15:0] as_a;
  logic [15:0] as_sum;
  logic        as_sub;
  logic        as_cout;
  logic [15:0] trial_a;
  logic        take;

  assign opcode = ir[15:8];
  assign zflag  = (acc == 16'h0000);
  assign alu_op = alu_op_of(opcode);

  assign mem_addr  = mar;
  assign mem_wdata = acc;
  assign mem_we    = (state == S_ST) && !Reset;

  // Partial remainder shifted left with the next dividend bit; bit 16 is rem[15].
  assign trial_a = {rem[14:0], quo[15]};
  assign take    = as_cout | rem[15];

  always_comb begin
    as_a   = acc;
    as_sub = (alu_op == ALU_SUB);
    if (state == S_DV) begin
      as_a   = trial_a;
      as_sub = 1'b1;
    end
  end

  addsub16 u_addsub (
    .a    (as_a),
    .b    (mdr),
    .sub  (as_sub),
    .sum  (as_sum),
    .cout (as_cout)
  );

  always_comb begin
    case (alu_op)
      ALU_ADD: alu_res = as_sum;
      ALU_SUB: alu_res = as_sum;
      ALU_OR:  alu_res = acc | mdr;
      default: alu_res = mdr;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state   <= S_F1;
      pc      <= '0;
      mar     <= '0;
      ir      <= '0;
      mdr     <= '0;
      acc     <= '0;
      rem     <= '0;
      quo     <= '0;
      div_cnt <= '0;
    end else begin
      case (state)
        S_F1: begin
          mar   <= pc;
          state <= S_F2;
        end
        S_F2: begin
          mdr   <= mem_rdata;
          pc    <= pc + 8'd1;
          state <= S_F3;
        end
        S_F3: begin
          ir    <= mdr;
          state <= S_D;
        end
        S_D: begin
          mar <= ir[7:0];
          case (opcode)
            OP_ADD, OP_SUB, OP_OR, OP_LOAD, OP_DIV: state <= S_X1;
            OP_STORE: state <= S_ST;
            OP_JUMP: begin
              pc    <= ir[7:0];
              state <= S_F1;
            end
            OP_JUMPZ: begin
              if (zflag) pc <= ir[7:0];
              state <= S_F1;
            end
            OP_HALT: state <= S_H;
            default: state <= S_F1;
          endcase
        end
        S_X1: begin
          mdr <= mem_rdata;
          if (opcode == OP_DIV) begin
            rem     <= '0;
            quo     <= acc;
            div_cnt <= 5'd16;
            state   <= S_DV;
          end else begin
            state <= S_X2;
          end
        end
        S_X2: begin
          acc   <= alu_res;
          state <= S_F1;
        end
        S_ST: state <= S_F1;
        S_DV: begin
          if (div_cnt == 5'd0) begin
            acc   <= quo;
            state <= S_F1;
          end else begin
            rem     <= take ? as_sum : trial_a;
            quo     <= {quo[14:0], take};
            div_cnt <= div_cnt - 5'd1;
          end
        end
        S_H: state <= S_H;
        default: state <= S_F1;
      endcase
    end
  end

endmodule

// File: tb/tb_accum_cpu_core.sv
// Bench for accum_cpu_core: directed and random programs checked against an
// instruction-level model of the machine with per-instruction cycle costs.
module tb_accum_cpu_core;

  logic        clk;
  logic        Reset;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_we;
  logic [15:0] mem_rdata;

  logic [15:0] ram [256];
  logic [15:0] img [256];
  logic [15:0] mm  [256];

  typedef struct {
    int          cyc;
    logic [7:0]  a;
    logic [15:0] d;
  } wr_t;

  wr_t act_q[$];
  wr_t exp_q[$];

  int          cyc;
  int          checks;
  int          errors;
  int          halt_cyc;
  logic [7:0]  halt_a;
  logic [15:0] exp_acc;

  accum_cpu_core dut (
    .clk       (clk),
    .Reset     (Reset),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = ram[mem_addr];

  // cyc holds the index of the current edge counted from reset release.
  always @(posedge clk) begin
    if (Reset) cyc <= 0;
    else cyc <= cyc + 1;
    if (!Reset && mem_we) begin
      act_q.push_back('{cyc, mem_addr, mem_wdata});
      ram[mem_addr] <= mem_wdata;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_img();
    for (int i = 0; i < 256; i++) img[i] = 16'h0000;
  endtask

  // Instruction-level reference: costs are cycles from one F1 to the next.
  task automatic model_run();
    logic [7:0]  pc;
    logic [15:0] acc;
    logic [15:0] ir;
    logic [15:0] m;
    logic [7:0]  op;
    logic [7:0]  a;
    int          c;
    bit          halted;
    for (int i = 0; i < 256; i++) mm[i] = img[i];
    exp_q.delete();
    pc = 8'h00; acc = 16'h0000; c = 0; halted = 0; halt_cyc = 0; halt_a = 8'h00;
    for (int n = 0; n < 400 && !halted; n++) begin
      ir = mm[pc];
      pc = pc + 8'd1;
      op = ir[15:8];
      a  = ir[7:0];
      m  = mm[a];
      case (op)
        8'h01: begin acc = acc + m; c += 6; end
        8'h02: begin acc = acc - m; c += 6; end
        8'h03: begin acc = acc | m; c += 6; end
        8'h04: begin acc = m; c += 6; end
        8'h05: begin exp_q.push_back('{c + 4, a, acc}); mm[a] = acc; c += 5; end
        8'h06: begin pc = a; c += 4; end
        8'h07: begin if (acc == 16'h0000) pc = a; c += 4; end
        8'h08: begin acc = (m == 16'h0000) ? 16'hFFFF : acc / m; c += 22; end
        8'hFF: begin halted = 1; halt_cyc = c + 4; halt_a = a; end
        default: c += 4;
      endcase
    end
    exp_acc = acc;
  endtask

  task automatic load_prog();
    @(negedge clk);
    Reset = 1'b1;
    for (int i = 0; i < 256; i++) ram[i] = img[i];
    repeat (2) @(negedge clk);
    act_q.delete();
    model_run();
  endtask

  task automatic release_rst();
    @(negedge clk);
    Reset = 1'b0;
  endtask

  task automatic finish_prog(input string tag);
    int guard;
    int bad;
    int stuck;
    int n;
    guard = 0;
    while (cyc < halt_cyc + 8 && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    check({tag, " run-bound"}, 32'(guard < 20000), 32'd1);
    check({tag, " n-writes"}, act_q.size(), exp_q.size());
    n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check({tag, " wr-cycle"}, act_q[i].cyc, exp_q[i].cyc);
      check({tag, " wr-addr"}, {24'h0, act_q[i].a}, {24'h0, exp_q[i].a});
      check({tag, " wr-data"}, {16'h0, act_q[i].d}, {16'h0, exp_q[i].d});
    end
    bad = 0;
    for (int i = 0; i < 256; i++) if (ram[i] !== mm[i]) bad++;
    check({tag, " ram-diffs"}, bad, 0);
    check({tag, " final-acc"}, {16'h0, mem_wdata}, {16'h0, exp_acc});
    check({tag, " halt-addr"}, {24'h0, mem_addr}, {24'h0, halt_a});
    stuck = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (mem_we !== 1'b0) stuck++;
    end
    check({tag, " halt-we"}, stuck, 0);
  endtask

  task automatic basic_img();
    clear_img();
    img[8'h00] = 16'h040A; img[8'h01] = 16'h010B;
    img[8'h02] = 16'h050E; img[8'h03] = 16'hFF00;
    img[8'h0A] = 16'h0014; img[8'h0B] = 16'h0003;
  endtask

  task automatic div_img(input logic [15:0] x, input logic [15:0] y);
    clear_img();
    img[8'h00] = 16'h040A; img[8'h01] = 16'h080B;
    img[8'h02] = 16'h050E; img[8'h03] = 16'hFF00;
    img[8'h0A] = x; img[8'h0B] = y;
  endtask

  logic [15:0] dv_x [3];
  logic [15:0] dv_y [3];
  logic [15:0] dv_q [3];
  int          kind;
  logic [7:0]  rop;

  initial begin
    checks = 0; errors = 0;
    Reset = 1'b1;
    clear_img();
    for (int i = 0; i < 256; i++) ram[i] = 16'h0000;
    repeat (3) @(negedge clk);
    check("reset addr", {24'h0, mem_addr}, 32'h0);
    check("reset acc", {16'h0, mem_wdata}, 32'h0);
    check("reset we", {31'h0, mem_we}, 32'h0);

    basic_img();
    load_prog(); release_rst(); finish_prog("basic");
    check("basic M0E", {16'h0, ram[8'h0E]}, 32'h0017);

    dv_x[0] = 16'd100; dv_y[0] = 16'd7; dv_q[0] = 16'h000E;
    dv_x[1] = 16'd100; dv_y[1] = 16'd0; dv_q[1] = 16'hFFFF;
    dv_x[2] = 16'd5;   dv_y[2] = 16'd9; dv_q[2] = 16'h0000;
    for (int t = 0; t < 3; t++) begin
      div_img(dv_x[t], dv_y[t]);
      load_prog(); release_rst();
      repeat (27) @(negedge clk);
      check("div acc-before", {16'h0, mem_wdata}, {16'h0, dv_x[t]});
      @(negedge clk);
      check("div acc-after", {16'h0, mem_wdata}, {16'h0, dv_q[t]});
      finish_prog("div");
      check("div M0E", {16'h0, ram[8'h0E]}, {16'h0, dv_q[t]});
    end

    clear_img();
    img[8'h00] = 16'h040A; img[8'h01] = 16'h020A; img[8'h02] = 16'h0710;
    img[8'h03] = 16'h050F; img[8'h04] = 16'hFF00;
    img[8'h10] = 16'h050E; img[8'h11] = 16'hFF00;
    img[8'h0A] = 16'h1234; img[8'h0E] = 16'hBEEF; img[8'h0F] = 16'hDEAD;
    load_prog(); release_rst(); finish_prog("jz-taken");
    check("jz-taken M0E", {16'h0, ram[8'h0E]}, 32'h0000);
    check("jz-taken M0F", {16'h0, ram[8'h0F]}, 32'hDEAD);

    clear_img();
    img[8'h00] = 16'h040A; img[8'h01] = 16'h020B; img[8'h02] = 16'h0710;
    img[8'h03] = 16'h050E; img[8'h04] = 16'hFF00;
    img[8'h10] = 16'h050F; img[8'h11] = 16'hFF00;
    img[8'h0A] = 16'h0009; img[8'h0B] = 16'h0004; img[8'h0F] = 16'hDEAD;
    load_prog(); release_rst(); finish_prog("jz-fall");
    check("jz-fall M0E", {16'h0, ram[8'h0E]}, 32'h0005);
    check("jz-fall M0F", {16'h0, ram[8'h0F]}, 32'hDEAD);

    clear_img();
    img[8'h00] = 16'h040A; img[8'h01] = 16'h010B; img[8'h02] = 16'h050E;
    img[8'h03] = 16'h040C; img[8'h04] = 16'h020D; img[8'h05] = 16'h050F;
    img[8'h06] = 16'hFF00;
    img[8'h0A] = 16'hFFFF; img[8'h0B] = 16'h0002; img[8'h0C] = 16'h0000; img[8'h0D] = 16'h0001;
    load_prog(); release_rst(); finish_prog("wrap");
    check("add wrap", {16'h0, ram[8'h0E]}, 32'h0001);
    check("sub wrap", {16'h0, ram[8'h0F]}, 32'hFFFF);

    clear_img();
    img[8'h00] = 16'h0710; img[8'h01] = 16'h050E; img[8'h02] = 16'hFF00;
    img[8'h10] = 16'h0420; img[8'h11] = 16'h06FF; img[8'hFF] = 16'h0000;
    img[8'h20] = 16'h0005;
    load_prog(); release_rst(); finish_prog("pc-wrap");
    check("pc-wrap M0E", {16'h0, ram[8'h0E]}, 32'h0005);

    div_img(16'd100, 16'd7);
    load_prog(); release_rst();
    repeat (15) @(negedge clk);
    Reset = 1'b1;
    @(negedge clk);
    check("rst-dv addr", {24'h0, mem_addr}, 32'h0);
    check("rst-dv acc", {16'h0, mem_wdata}, 32'h0);
    check("rst-dv we", {31'h0, mem_we}, 32'h0);
    act_q.delete();
    release_rst(); finish_prog("rst-dv");
    check("rst-dv M0E", {16'h0, ram[8'h0E]}, 32'h000E);

    basic_img();
    load_prog(); release_rst();
    repeat (16) @(negedge clk);
    check("st we-high", {31'h0, mem_we}, 32'h1);
    Reset = 1'b1;
    #1;
    check("st we-gated", {31'h0, mem_we}, 32'h0);
    @(negedge clk);
    check("rst-st addr", {24'h0, mem_addr}, 32'h0);
    check("rst-st acc", {16'h0, mem_wdata}, 32'h0);
    check("rst-st we", {31'h0, mem_we}, 32'h0);
    check("rst-st no-write", act_q.size(), 0);
    check("rst-st M0E", {16'h0, ram[8'h0E]}, 32'h0000);
    act_q.delete();
    release_rst(); finish_prog("rst-st");
    check("rst-st M0E final", {16'h0, ram[8'h0E]}, 32'h0017);

    for (int t = 0; t < 8; t++) begin
      clear_img();
      for (int i = 8'h80; i < 8'h8F; i++)
        img[i] = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 20)) : 16'($urandom);
      img[8'h8F] = 16'h0000;
      for (int p = 0; p < 19; p++) begin
        kind = $urandom_range(0, 9);
        case (kind)
          0, 1, 2, 3, 4: begin
            rop = 8'(kind + 1);
            if (kind == 4) rop = 8'h08;
            img[p] = {rop, 8'(8'h80 + $urandom_range(0, 15))};
          end
          5, 6: img[p] = {8'h05, 8'(8'hC0 + $urandom_range(0, 15))};
          7: img[p] = {8'h07, 8'(p + 2)};
          8: img[p] = {8'(8'h09 + $urandom_range(0, 32)), 8'($urandom)};
          default: img[p] = 16'h048F;
        endcase
      end
      img[19] = 16'h05CF;
      img[20] = 16'hFF00;
      load_prog(); release_rst(); finish_prog("random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
